fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_if_id_reg.sv | 36 +++
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage: reset/base addresses, NOP encoding,
// IF/ID field layout and the bad-PC predicate.
package fetch_unit_pkg;

  localparam int          PC_W         = 32;
  localparam int          INSTR_W      = 32;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
    logic               valid;
    logic               err;
  } if_id_t;

  // Limit is carried in 33 bits so a memory ending at 2^32 still compares correctly.
  function automatic logic pc_bad(input logic [31:0] pc, input logic [31:0] base,
                                  input logic [32:0] limit);
    pc_bad = (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   stall_i,
  input  logic   flush_i,
  input  if_id_t fetch_i,
  output if_id_t if_id_o
);

  if_id_t if_id_d, if_id_q;

  always_comb begin
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d = '0;
    end else if (stall_i) begin
      if_id_d = if_id_q;
    end else begin
      if_id_d = fetch_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      if_id_q <= '0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection, bad-PC screening,
// and the IF/ID register feeding decode (delayed-branch, no redirect flush).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic        fetch_err_d
);

  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_q, pc_d;
  logic [31:0] im_offset_s;
  logic        pc_bad_s;
  logic        unused_offset_bits;
  if_id_t      fetch_s, if_id_s;

  assign im_offset_s        = pc_q - IM_BASE;
  assign im_addr            = im_offset_s[11:2];
  assign unused_offset_bits = ^{im_offset_s[31:12], im_offset_s[1:0]};
  assign pc_bad_s           = pc_bad(pc_q, IM_BASE, IM_LIMIT);

  // A bad PC still produces a valid slot, just with a NOP and the error flag.
  always_comb begin
    fetch_s       = '0;
    fetch_s.instr = pc_bad_s ? NOP_INSTR : im_instr;
    fetch_s.pc4   = pc_q + 32'd4;
    fetch_s.valid = 1'b1;
    fetch_s.err   = pc_bad_s;
  end

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (stall) begin
      pc_d = pc_q;
    end else if (redirect_en) begin
      pc_d = redirect_pc;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (clk),
    .rst_n_i (reset),
    .stall_i (stall),
    .flush_i (flush),
    .fetch_i (fetch_s),
    .if_id_o (if_id_s)
  );

  assign pc_f        = pc_q;
  assign instr_d     = if_id_s.instr;
  assign pc4_d       = if_id_s.pc4;
  assign valid_d     = if_id_s.valid;
  assign fetch_err_d = if_id_s.err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural model pushes expected state into a
// scoreboard queue per step; results are popped and checked with immediate assertions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_en;
  logic [31:0] redirect_pc;
  logic [9:0]  im_addr;
  logic [31:0] im_instr;
  logic [31:0] pc_f, instr_d, pc4_d;
  logic        valid_d, fetch_err_d;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_err;

  always #5 clk = ~clk;

  // Instruction memory: word k holds value k.
  assign im_instr = {22'd0, im_addr};

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .im_addr     (im_addr),
    .im_instr    (im_instr),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc4_d       (pc4_d),
    .valid_d     (valid_d),
    .fetch_err_d (fetch_err_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_v, input logic st, input logic fl,
                      input logic re, input logic [31:0] rpc);
    exp_t        e;
    logic        bad;
    logic [31:0] off;
    reset       = rst_v;
    stall       = st;
    flush       = fl;
    redirect_en = re;
    redirect_pc = rpc;
    off = m_pc - 32'h3000;
    bad = (m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc >= 32'h4000);
    if (!rst_v) begin
      m_pc = 32'h3000; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      if (fl) begin
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_err = 1'b0;
      end else if (!st) begin
        m_instr = bad ? 32'd0 : {22'd0, off[11:2]};
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_err   = bad;
      end
      if (!st) m_pc = re ? rpc : m_pc + 32'd4;
    end
    e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, err: m_err};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("pc_f",        pc_f,                 e.pc);
    chk("instr_d",     instr_d,              e.instr);
    chk("pc4_d",       pc4_d,                e.pc4);
    chk("valid_d",     {31'd0, valid_d},     {31'd0, e.valid});
    chk("fetch_err_d", {31'd0, fetch_err_d}, {31'd0, e.err});
    off = e.pc - 32'h3000;
    chk("im_addr",     {22'd0, im_addr},     {22'd0, off[11:2]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_err = 1'b0;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = '0;

    // Reset, then free run for three clocks.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_pc", pc_f, 32'h3000);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("run_pc", pc_f, 32'h300C);
    chk("run_instr", instr_d, 32'd2);
    chk("run_pc4", pc4_d, 32'h300C);
    chk("run_valid", {31'd0, valid_d}, 32'd1);

    // Two-cycle stall at 0x3008.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_stall_pc", pc_f, 32'h3008);
    repeat (2) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_pc", pc_f, 32'h3008);
      chk("stall_instr", instr_d, 32'd1);
      chk("stall_pc4", pc4_d, 32'h3008);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("resume_pc", pc_f, 32'h300C);

    // Redirect at 0x3004 keeps the delay slot.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h3100);
    chk("redir_pc", pc_f, 32'h3100);
    chk("delay_slot_instr", instr_d, 32'd1);
    chk("delay_slot_valid", {31'd0, valid_d}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_redir_instr", instr_d, 32'h40);

    // Redirect + stall + flush together, then redirect alone.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h3200);
    chk("rsf_pc", pc_f, 32'h3104);
    chk("rsf_valid", {31'd0, valid_d}, 32'd0);
    chk("rsf_instr", instr_d, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h3200);
    chk("redir_again_pc", pc_f, 32'h3200);

    // Misaligned target.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h3002);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("mis_instr", instr_d, 32'd0);
    chk("mis_err", {31'd0, fetch_err_d}, 32'd1);
    chk("mis_valid", {31'd0, valid_d}, 32'd1);
    chk("mis_next_pc", pc_f, 32'h3006);

    // Out-of-range target.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h4000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("oor_instr", instr_d, 32'd0);
    chk("oor_err", {31'd0, fetch_err_d}, 32'd1);
    chk("oor_next_pc", pc_f, 32'h4004);

    // Last in-range word, then wrap-around past 0xFFFFFFFC.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h3FFC);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("last_word_instr", instr_d, 32'h3FF);
    chk("last_word_err", {31'd0, fetch_err_d}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc_f, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("low_err", {31'd0, fetch_err_d}, 32'd1);

    // Reset mid-operation with stall and redirect pending.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h3500);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h3600);
    chk("midrst_pc", pc_f, 32'h3000);
    chk("midrst_valid", {31'd0, valid_d}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("after_rst_pc4", pc4_d, 32'h3004);
    chk("after_rst_instr", instr_d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
